sprite_obj_engine: RTL

//  Parametrised player-sprite engine; successor to the single-object display block.
//  - Moves one sprite under up/down/left/right at a programmable rate.
//  - Erases the old footprint, then redraws from external sprite ROM with transparency.
//  - Checks N enemy bullets every cycle for collision and latches game-over.
//  - Sits between keypad/bullet logic and the VGA adapter plot port.

---
 rtl/sprite_obj_engine.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/sprite_obj_engine.sv
// -----------------------------------------------------------------------------
// sprite_obj_engine
//   Player-sprite engine placed between the keypad/bullet logic and the VGA
//   adapter plot port. It draws one SPR_W x SPR_H sprite from an external ROM
//   (skipping the transparent colour), moves it under up/down/left/right once
//   per move tick (erase old footprint, then redraw), and checks N_BUL enemy
//   bullets every active cycle for a hit, which latches game-over.
//
// Ports
//   CLOCK_50, rstn            clock, asynchronous active-low reset
//   startn                    active-low start level (sampled in IDLE only)
//   up, down, left, right     move request levels (sampled at the move tick)
//   Obj_Memory_Color          sprite ROM data, valid one cycle after address
//   Memory_XC, Memory_YC      sprite ROM column / row address
//   bullet_x/_y/_valid        packed enemy bullet positions and enables
//   VGA_X_Pos, VGA_Y_Pos      plot coordinate
//   VGA_Color, VGA_Plot_EN    plot colour and one-pixel-per-cycle strobe
//   Obj_X, Obj_Y              current sprite top-left corner
//   busy                      high while erasing, drawing or flushing
//   game_over_en              sticky collision flag
//   LEDR                      one-hot state debug {GOVER, WAIT, DRAW, IDLE}
// -----------------------------------------------------------------------------
module sprite_obj_engine #(
   parameter int         SCREEN_W = 320,
   parameter int         SCREEN_H = 240,
   parameter int         SPR_W    = 16,
   parameter int         SPR_H    = 16,
   parameter int         INIT_X   = 152,
   parameter int         INIT_Y   = 112,
   parameter int         STEP     = 2,
   parameter int         MOVE_DIV = 833333,
   parameter int         N_BUL    = 4,
   parameter logic [2:0] BG_COLOR = 3'b000,
   parameter logic [2:0] TRANSP   = 3'b111
) (
   input  logic                     CLOCK_50,
   input  logic                     rstn,
   input  logic                     startn,
   input  logic                     up,
   input  logic                     down,
   input  logic                     left,
   input  logic                     right,
   input  logic [2:0]               Obj_Memory_Color,
   output logic [$clog2(SPR_W)-1:0] Memory_XC,
   output logic [$clog2(SPR_H)-1:0] Memory_YC,
   input  logic [9*N_BUL-1:0]       bullet_x,
   input  logic [8*N_BUL-1:0]       bullet_y,
   input  logic [N_BUL-1:0]         bullet_valid,
   output logic [8:0]               VGA_X_Pos,
   output logic [7:0]               VGA_Y_Pos,
   output logic [2:0]               VGA_Color,
   output logic                     VGA_Plot_EN,
   output logic [8:0]               Obj_X,
   output logic [7:0]               Obj_Y,
   output logic                     busy,
   output logic                     game_over_en,
   output logic [3:0]               LEDR
);

   localparam int XW = $clog2(SPR_W);
   localparam int YW = $clog2(SPR_H);
   localparam int CW = XW + YW;
   localparam int TW = $clog2(MOVE_DIV);
   localparam logic [CW-1:0]     CNT_LAST  = '1;
   localparam logic [TW-1:0]     TICK_LAST = TW'(MOVE_DIV - 1);
   localparam logic signed [9:0] MAX_X     = 10'(SCREEN_W - SPR_W);
   localparam logic signed [9:0] MAX_Y     = 10'(SCREEN_H - SPR_H);
   localparam logic signed [9:0] STEP_S    = 10'(STEP);

   typedef enum logic [2:0] {S_IDLE, S_DRAW, S_FLUSH, S_WAIT, S_ERASE, S_GOVER} state_t;

   state_t         state_q, state_d;
   logic [8:0]     obj_x_q, obj_x_d, nxt_x_q, nxt_x_d, vga_x_q, vga_x_d;
   logic [7:0]     obj_y_q, obj_y_d, nxt_y_q, nxt_y_d, vga_y_q, vga_y_d;
   logic [CW-1:0]  cnt_q, cnt_d;
   logic [TW-1:0]  tick_q, tick_d;
   logic           pix_vld_q, pix_vld_d, pix_bg_q, pix_bg_d;
   logic           gover_q, gover_d, busy_q;
   logic [3:0]     led_q;

   logic signed [9:0] dx, dy, nx_raw, ny_raw;
   logic [8:0]        nx_cl;
   logic [7:0]        ny_cl;
   logic [9:0]        ox10, oy10;
   logic              hit;

   // Debug LEDs: erase and flush are shown as the drawing phase.
   function automatic logic [3:0] led_of(input state_t s);
      case (s)
         S_IDLE:  led_of = 4'b0001;
         S_WAIT:  led_of = 4'b0100;
         S_GOVER: led_of = 4'b1000;
         default: led_of = 4'b0010;
      endcase
   endfunction

   // Candidate position for the next move tick, clamped to the screen.
   always_comb begin
      dx = 10'sd0;
      dy = 10'sd0;
      if (right) dx = dx + STEP_S;
      if (left)  dx = dx - STEP_S;
      if (down)  dy = dy + STEP_S;
      if (up)    dy = dy - STEP_S;
      nx_raw = $signed({1'b0, obj_x_q}) + dx;
      ny_raw = $signed({2'b00, obj_y_q}) + dy;
      if (nx_raw < 10'sd0)     nx_cl = 9'd0;
      else if (nx_raw > MAX_X) nx_cl = MAX_X[8:0];
      else                     nx_cl = nx_raw[8:0];
      if (ny_raw < 10'sd0)     ny_cl = 8'd0;
      else if (ny_raw > MAX_Y) ny_cl = MAX_Y[7:0];
      else                     ny_cl = ny_raw[7:0];
   end

   // Bullet hit test against the current footprint; compared in 10 bits so
   // the right/bottom edge (up to SCREEN_W) cannot overflow.
   assign ox10 = {1'b0, obj_x_q};
   assign oy10 = {2'b00, obj_y_q};

   always_comb begin
      hit = 1'b0;
      for (int i = 0; i < N_BUL; i++) begin
         if (bullet_valid[i] &&
             ({1'b0, bullet_x[9*i +: 9]} >= ox10) &&
             ({1'b0, bullet_x[9*i +: 9]} <  ox10 + 10'(SPR_W)) &&
             ({2'b00, bullet_y[8*i +: 8]} >= oy10) &&
             ({2'b00, bullet_y[8*i +: 8]} <  oy10 + 10'(SPR_H)))
            hit = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      obj_x_d   = obj_x_q;
      obj_y_d   = obj_y_q;
      nxt_x_d   = nxt_x_q;
      nxt_y_d   = nxt_y_q;
      vga_x_d   = vga_x_q;
      vga_y_d   = vga_y_q;
      cnt_d     = cnt_q;
      tick_d    = '0;
      pix_vld_d = 1'b0;
      pix_bg_d  = 1'b0;
      gover_d   = gover_q;
      case (state_q)
         S_IDLE: begin
            if (!startn) begin
               state_d = S_DRAW;
               cnt_d   = '0;
            end
         end
         S_DRAW, S_ERASE: begin
            // Position is registered alongside the ROM read so it lines up
            // with the colour returned one cycle later.
            pix_vld_d = 1'b1;
            pix_bg_d  = (state_q == S_ERASE);
            vga_x_d   = obj_x_q + 9'(cnt_q[XW-1:0]);
            vga_y_d   = obj_y_q + 8'(cnt_q[CW-1:XW]);
            cnt_d     = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               if (state_q == S_DRAW) begin
                  state_d = S_FLUSH;
               end else begin
                  state_d = S_DRAW;
                  obj_x_d = nxt_x_q;
                  obj_y_d = nxt_y_q;
               end
            end
         end
         S_FLUSH: state_d = S_WAIT;
         S_WAIT: begin
            tick_d = tick_q + TW'(1);
            if (tick_q == TICK_LAST) begin
               tick_d = '0;
               if ((nx_cl != obj_x_q) || (ny_cl != obj_y_q)) begin
                  state_d = S_ERASE;
                  nxt_x_d = nx_cl;
                  nxt_y_d = ny_cl;
                  cnt_d   = '0;
               end
            end
         end
         default: state_d = S_GOVER;
      endcase
      // A hit overrides any transition and drops the pixel in flight.
      if (hit && (state_q != S_IDLE) && (state_q != S_GOVER)) begin
         state_d   = S_GOVER;
         gover_d   = 1'b1;
         pix_vld_d = 1'b0;
      end
   end

   always_ff @(posedge CLOCK_50 or negedge rstn) begin
      if (!rstn) begin
         state_q   <= S_IDLE;
         obj_x_q   <= 9'(INIT_X);
         obj_y_q   <= 8'(INIT_Y);
         nxt_x_q   <= 9'(INIT_X);
         nxt_y_q   <= 8'(INIT_Y);
         vga_x_q   <= '0;
         vga_y_q   <= '0;
         cnt_q     <= '0;
         tick_q    <= '0;
         pix_vld_q <= 1'b0;
         pix_bg_q  <= 1'b0;
         gover_q   <= 1'b0;
         busy_q    <= 1'b0;
         led_q     <= 4'b0001;
      end else begin
         state_q   <= state_d;
         obj_x_q   <= obj_x_d;
         obj_y_q   <= obj_y_d;
         nxt_x_q   <= nxt_x_d;
         nxt_y_q   <= nxt_y_d;
         vga_x_q   <= vga_x_d;
         vga_y_q   <= vga_y_d;
         cnt_q     <= cnt_d;
         tick_q    <= tick_d;
         pix_vld_q <= pix_vld_d;
         pix_bg_q  <= pix_bg_d;
         gover_q   <= gover_d;
         busy_q    <= (state_d == S_DRAW) || (state_d == S_ERASE) || (state_d == S_FLUSH);
         led_q     <= led_of(state_d);
      end
   end

   // Colour comes straight from the ROM in the cycle after the address;
   // gating with the registered valid keeps it 0 outside plotting.
   assign VGA_Color    = pix_vld_q ? (pix_bg_q ? BG_COLOR : Obj_Memory_Color) : 3'b000;
   assign VGA_Plot_EN  = pix_vld_q && (pix_bg_q || (Obj_Memory_Color != TRANSP));
   assign VGA_X_Pos    = vga_x_q;
   assign VGA_Y_Pos    = vga_y_q;
   assign Memory_XC    = cnt_q[XW-1:0];
   assign Memory_YC    = cnt_q[CW-1:XW];
   assign Obj_X        = obj_x_q;
   assign Obj_Y        = obj_y_q;
   assign busy         = busy_q;
   assign game_over_en = gover_q;
   assign LEDR         = led_q;

endmodule
